sa_autosa_cdp_rdma_reg_multi: RTL and testbench

SA_AUTOSA_CDP_RDMA_REG_MULTI -- requirements
Module: sa_autosa_cdp_rdma_reg_multi

---
 rtl/sa_autosa_cdp_rdma_reg_multi.sv | 148 ++++++++++++++
 tb/tb_sa_autosa_cdp_rdma_reg_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_autosa_cdp_rdma_reg_multi.sv
// Ping-pong register-group controller for the CDP RDMA block.
// Software arms groups in producer order; hardware runs them one at a time in consumer order.
module sa_autosa_cdp_rdma_reg_multi #(
    parameter  int NUM_GROUPS = 2,
    localparam int PTR_W      = (NUM_GROUPS > 2) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                  autosa_core_clk,
    input  logic                  autosa_core_rstn,
    input  logic [11:0]           reg_offset,
    input  logic [31:0]           reg_wr_data,
    input  logic                  reg_wr_en,
    output logic [31:0]           reg_rd_data,
    input  logic                  op_done,
    output logic [PTR_W-1:0]      producer,
    output logic [PTR_W-1:0]      consumer,
    output logic [NUM_GROUPS-1:0] op_en,
    output logic                  op_start,
    output logic                  err_irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RUNNING = 2'd2
    } grp_state_e;

    localparam logic [11:0] OFS_STATUS  = 12'h000;
    localparam logic [11:0] OFS_POINTER = 12'h004;
    localparam logic [11:0] OFS_OP_EN   = 12'h008;
    localparam logic [11:0] OFS_ERR     = 12'h00C;

    grp_state_e       state_q [NUM_GROUPS];
    grp_state_e       state_d [NUM_GROUPS];
    logic [PTR_W-1:0] producer_q, producer_d;
    logic [PTR_W-1:0] consumer_q, consumer_d;
    logic [3:0]       err_q, err_d;
    logic             start_q, start_d;

    logic [3:0]       err_set;
    logic [3:0]       err_clr;
    logic             any_running;

    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            state_d[g] = state_q[g];
        end
        producer_d  = producer_q;
        consumer_d  = consumer_q;
        start_d     = 1'b0;
        err_set     = '0;
        err_clr     = '0;
        any_running = 1'b0;

        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (state_q[g] == RUNNING) any_running = 1'b1;
        end

        if (reg_wr_en) begin
            case (reg_offset)
                OFS_STATUS: err_set[0] = 1'b1;
                OFS_POINTER: begin
                    // The whole word is the producer value; anything out of range is refused.
                    if (reg_wr_data >= 32'(NUM_GROUPS)) err_set[1] = 1'b1;
                    else                                producer_d = reg_wr_data[PTR_W-1:0];
                end
                OFS_OP_EN: begin
                    if (reg_wr_data[0]) begin
                        if (state_q[producer_q] != IDLE) err_set[2] = 1'b1;
                        else                             state_d[producer_q] = PENDING;
                    end
                end
                OFS_ERR: err_clr = reg_wr_data[3:0];
                default: err_set[1] = 1'b1;
            endcase
        end

        // Only the consumer group can be running, so completion always retires it.
        if (op_done) begin
            if (state_q[consumer_q] == RUNNING) begin
                state_d[consumer_q] = IDLE;
                consumer_d = (int'(consumer_q) == NUM_GROUPS - 1) ? '0 : consumer_q + 1'b1;
            end else begin
                err_set[3] = 1'b1;
            end
        end

        if (!any_running && state_q[consumer_q] == PENDING) begin
            state_d[consumer_q] = RUNNING;
            start_d = 1'b1;
        end

        // Hardware set beats a software clear of the same bit.
        err_d = (err_q & ~err_clr) | err_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                state_q[g] <= IDLE;
            end
            producer_q <= '0;
            consumer_q <= '0;
            err_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                state_q[g] <= state_d[g];
            end
            producer_q <= producer_d;
            consumer_q <= consumer_d;
            err_q      <= err_d;
            start_q    <= start_d;
        end
    end

    always_comb begin
        op_en = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            op_en[g] = (state_q[g] == PENDING) || (state_q[g] == RUNNING);
        end
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_offset)
            OFS_STATUS: begin
                for (int g = 0; g < NUM_GROUPS; g++) begin
                    reg_rd_data[4*g +: 2] = state_q[g];
                end
            end
            OFS_POINTER: begin
                reg_rd_data[PTR_W-1:0]  = producer_q;
                reg_rd_data[16 +: PTR_W] = consumer_q;
            end
            OFS_OP_EN: reg_rd_data[0]   = op_en[producer_q];
            OFS_ERR:   reg_rd_data[3:0] = err_q;
            default:   reg_rd_data = '0;
        endcase
    end

    assign producer = producer_q;
    assign consumer = consumer_q;
    assign op_start = start_q;
    assign err_irq  = |err_q;

endmodule

// File: tb/tb_sa_autosa_cdp_rdma_reg_multi.sv
// Directed bench: a two-group and a four-group instance driven with hand-computed expectations.
`timescale 1ns/100ps
module tb_sa_autosa_cdp_rdma_reg_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Two-group instance
    logic        rst_a;
    logic [11:0] ofs_a;
    logic [31:0] wd_a, rd_a;
    logic        we_a, done_a, start_a, irq_a;
    logic [0:0]  prod_a, cons_a;
    logic [1:0]  en_a;

    // Four-group instance
    logic        rst_b;
    logic [11:0] ofs_b;
    logic [31:0] wd_b, rd_b;
    logic        we_b, done_b, start_b, irq_b;
    logic [1:0]  prod_b, cons_b;
    logic [3:0]  en_b;

    sa_autosa_cdp_rdma_reg_multi #(.NUM_GROUPS(2)) u_dut_a (
        .autosa_core_clk (clk),
        .autosa_core_rstn(rst_a),
        .reg_offset      (ofs_a),
        .reg_wr_data     (wd_a),
        .reg_wr_en       (we_a),
        .reg_rd_data     (rd_a),
        .op_done         (done_a),
        .producer        (prod_a),
        .consumer        (cons_a),
        .op_en           (en_a),
        .op_start        (start_a),
        .err_irq         (irq_a)
    );

    sa_autosa_cdp_rdma_reg_multi #(.NUM_GROUPS(4)) u_dut_b (
        .autosa_core_clk (clk),
        .autosa_core_rstn(rst_b),
        .reg_offset      (ofs_b),
        .reg_wr_data     (wd_b),
        .reg_wr_en       (we_b),
        .reg_rd_data     (rd_b),
        .op_done         (done_b),
        .producer        (prod_b),
        .consumer        (cons_b),
        .op_en           (en_b),
        .op_start        (start_b),
        .err_irq         (irq_b)
    );

    // Group index recorded at every op_start pulse of the four-group instance
    int start_log[$];
    always @(negedge clk) begin
        if (start_b) start_log.push_back(int'(cons_b));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input bit b, input logic [11:0] off, input logic [31:0] data, input bit done = 1'b0);
        @(negedge clk);
        if (!b) begin ofs_a = off; wd_a = data; we_a = 1'b1; done_a = done; end
        else    begin ofs_b = off; wd_b = data; we_b = 1'b1; done_b = done; end
        @(negedge clk);
        if (!b) begin we_a = 1'b0; done_a = 1'b0; end
        else    begin we_b = 1'b0; done_b = 1'b0; end
    endtask

    task automatic pulse_done(input bit b);
        @(negedge clk);
        if (!b) done_a = 1'b1; else done_b = 1'b1;
        @(negedge clk);
        if (!b) done_a = 1'b0; else done_b = 1'b0;
    endtask

    task automatic rdchk(input bit b, input logic [11:0] off, input logic [31:0] exp, input string tag);
        if (!b) ofs_a = off; else ofs_b = off;
        #0.5;
        check(tag, b ? rd_b : rd_a, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_before;
        rst_a = 1'b0; ofs_a = '0; wd_a = '0; we_a = 1'b0; done_a = 1'b0;
        rst_b = 1'b0; ofs_b = '0; wd_b = '0; we_b = 1'b0; done_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();

        // Reset state
        rdchk(0, 12'h004, 32'h0, "rst_pointer");
        rdchk(0, 12'h000, 32'h0, "rst_status");
        check("rst_op_en", {30'd0, en_a}, 32'h0);
        check("rst_irq", {31'd0, irq_a}, 32'h0);

        // Two-group ping-pong
        wr(0, 12'h008, 32'h1);
        check("arm0_start_low", {31'd0, start_a}, 32'h0);
        check("arm0_op_en", {30'd0, en_a}, 32'h1);
        rdchk(0, 12'h000, 32'h1, "arm0_pending");
        step();
        check("g0_start_pulse", {31'd0, start_a}, 32'h1);
        rdchk(0, 12'h000, 32'h2, "g0_running");
        wr(0, 12'h004, 32'h1);
        check("g0_start_one_cycle", {31'd0, start_a}, 32'h0);
        rdchk(0, 12'h004, 32'h1, "producer_1");
        wr(0, 12'h008, 32'h1);
        rdchk(0, 12'h000, 32'h12, "status_12");
        rdchk(0, 12'h008, 32'h1, "op_enable_rd");
        pulse_done(0);
        rdchk(0, 12'h004, 32'h00010001, "consumer_1");
        rdchk(0, 12'h000, 32'h10, "g0_retired");
        check("no_start_on_done", {31'd0, start_a}, 32'h0);
        step();
        check("g1_start_pulse", {31'd0, start_a}, 32'h1);
        rdchk(0, 12'h000, 32'h20, "status_20");
        step();
        check("g1_start_one_cycle", {31'd0, start_a}, 32'h0);
        pulse_done(0);
        rdchk(0, 12'h004, 32'h00000001, "consumer_wrap");
        rdchk(0, 12'h000, 32'h0, "all_idle");

        // Double arm rejected, then W1C
        wr(0, 12'h004, 32'h0);
        wr(0, 12'h008, 32'h1);
        wr(0, 12'h008, 32'h1);
        rdchk(0, 12'h00C, 32'h4, "arm_busy_err");
        check("arm_busy_irq", {31'd0, irq_a}, 32'h1);
        rdchk(0, 12'h000, 32'h2, "arm_busy_state_kept");
        wr(0, 12'h00C, 32'h4);
        rdchk(0, 12'h00C, 32'h0, "w1c_clear");
        check("w1c_irq_low", {31'd0, irq_a}, 32'h0);
        pulse_done(0);

        // Bad producer, RO write, undecoded write
        wr(0, 12'h004, 32'h3);
        rdchk(0, 12'h004, 32'h00010000, "bad_producer_kept");
        rdchk(0, 12'h00C, 32'h2, "bad_producer_err");
        wr(0, 12'h000, 32'hFFFF_FFFF);
        rdchk(0, 12'h00C, 32'h3, "ro_write_err");
        rdchk(0, 12'h000, 32'h0, "ro_write_no_effect");
        wr(0, 12'h010, 32'h1);
        rdchk(0, 12'h00C, 32'h3, "undecoded_err");
        rdchk(0, 12'h010, 32'h0, "undecoded_read");
        wr(0, 12'h00C, 32'hF);
        rdchk(0, 12'h00C, 32'h0, "clear_all");

        // Spurious done, set-over-clear, done coincident with arm
        pulse_done(0);
        rdchk(0, 12'h00C, 32'h8, "spurious_done_err");
        rdchk(0, 12'h004, 32'h00010000, "spurious_done_consumer");
        wr(0, 12'h00C, 32'h8, 1'b1);
        rdchk(0, 12'h00C, 32'h8, "set_beats_clear");
        wr(0, 12'h00C, 32'h8);
        rdchk(0, 12'h00C, 32'h0, "clear_after_set");
        wr(0, 12'h004, 32'h1);
        wr(0, 12'h008, 32'h1);
        step();
        rdchk(0, 12'h000, 32'h20, "g1_running_again");
        wr(0, 12'h008, 32'h1, 1'b1);
        rdchk(0, 12'h000, 32'h0, "coincident_idle");
        rdchk(0, 12'h00C, 32'h4, "coincident_rejected");
        rdchk(0, 12'h004, 32'h1, "coincident_consumer");

        // Four groups in consumer order with wrap
        wr(1, 12'h004, 32'h0); wr(1, 12'h008, 32'h1);
        wr(1, 12'h004, 32'h1); wr(1, 12'h008, 32'h1);
        wr(1, 12'h004, 32'h2); wr(1, 12'h008, 32'h1);
        wr(1, 12'h004, 32'h3); wr(1, 12'h008, 32'h1);
        rdchk(1, 12'h000, 32'h1112, "four_armed");
        check("four_op_en", {28'd0, en_b}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("consumer_at_3", {30'd0, cons_b}, 32'h3);
            pulse_done(1);
            step();
        end
        check("consumer_wrapped", {30'd0, cons_b}, 32'h0);
        rdchk(1, 12'h000, 32'h0, "four_idle");
        check("start_count", start_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < start_log.size()) check($sformatf("start_order_%0d", i), start_log[i], i);
        end

        // Reset while g1 running
        wr(1, 12'h004, 32'h0); wr(1, 12'h008, 32'h1);
        wr(1, 12'h004, 32'h1); wr(1, 12'h008, 32'h1);
        pulse_done(1);
        step();
        rdchk(1, 12'h000, 32'h20, "g1_running_b");
        n_before = start_log.size();
        #1 rst_b = 1'b0;
        rdchk(1, 12'h000, 32'h0, "reset_all_idle");
        rdchk(1, 12'h004, 32'h0, "reset_pointers");
        check("reset_op_en", {28'd0, en_b}, 32'h0);
        check("reset_op_start", {31'd0, start_b}, 32'h0);
        step();
        rst_b = 1'b1;
        repeat (3) step();
        check("reset_no_start", start_log.size(), n_before);
        rdchk(1, 12'h004, 32'h0, "reset_no_advance");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
